// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - branch/jump sequencer driving the CON flop and PC/link write ports
//
// Purpose: for each branch/jump instruction handed over by the control unit,
// strobe the condition flop, sample its registered result, compute the target
// and issue a single-cycle PC load (plus a link write for jal).
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   start        request pulse, accepted only when idle
//   ir           instruction word, sampled with start
//   pc_in        already-incremented PC, sampled with start
//   ra_value     Ra register contents, sampled with start
//   con_ff_out   registered branch condition from the CON flop
//   con_in       one-cycle enable to the CON flop
//   pc_out       new PC value, valid when pc_load=1
//   pc_load      one-cycle PC write enable
//   link_value   return address for jal
//   link_we      one-cycle link-register write enable
//   branch_taken asserted with done when the PC was loaded
//   illegal      asserted with done for an unsupported opcode
//   busy         high from the cycle after acceptance through the done cycle
//   done         one-cycle completion pulse

module branch_sequencer #(
    parameter logic [4:0] OPC_BR  = 5'b10010,
    parameter logic [4:0] OPC_JR  = 5'b10011,
    parameter logic [4:0] OPC_JAL = 5'b10100,
    parameter int         C_WIDTH = 19
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic [31:0] pc_in,
    input  logic [31:0] ra_value,
    input  logic        con_ff_out,
    output logic        con_in,
    output logic [31:0] pc_out,
    output logic        pc_load,
    output logic [31:0] link_value,
    output logic        link_we,
    output logic        branch_taken,
    output logic        illegal,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] STROBE = 3'd1;
    localparam logic [2:0] SAMPLE = 3'd2;
    localparam logic [2:0] JUMP   = 3'd3;
    localparam logic [2:0] FINISH = 3'd4;

    logic [2:0]         state;
    logic [4:0]         opCap;
    logic [C_WIDTH-1:0] dispCap;
    logic [31:0]        pcCap;
    logic [31:0]        raCap;
    logic [31:0]        branchTarget;

    // Bits between the opcode and the displacement carry no meaning here.
    logic unusedIrBits;
    assign unusedIrBits = ^ir[26:C_WIDTH];

    // Displacement is sign-extended; the add wraps modulo 2^32.
    assign branchTarget = pcCap + {{(32-C_WIDTH){dispCap[C_WIDTH-1]}}, dispCap};

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            opCap        <= '0;
            dispCap      <= '0;
            pcCap        <= '0;
            raCap        <= '0;
            con_in       <= 1'b0;
            pc_out       <= '0;
            pc_load      <= 1'b0;
            link_value   <= '0;
            link_we      <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opCap   <= ir[31:27];
                        dispCap <= ir[C_WIDTH-1:0];
                        pcCap   <= pc_in;
                        raCap   <= ra_value;
                        busy    <= 1'b1;
                        if (ir[31:27] == OPC_BR) begin
                            state  <= STROBE;
                            con_in <= 1'b1;
                        end else begin
                            state <= JUMP;
                        end
                    end
                end
                STROBE: begin
                    // CON flop captures on this edge; its result is valid next cycle.
                    con_in <= 1'b0;
                    state  <= SAMPLE;
                end
                SAMPLE: begin
                    if (con_ff_out) begin
                        pc_out       <= branchTarget;
                        pc_load      <= 1'b1;
                        branch_taken <= 1'b1;
                    end
                    done  <= 1'b1;
                    state <= FINISH;
                end
                JUMP: begin
                    if (opCap == OPC_JR || opCap == OPC_JAL) begin
                        pc_out       <= raCap;
                        pc_load      <= 1'b1;
                        branch_taken <= 1'b1;
                        if (opCap == OPC_JAL) begin
                            link_value <= pcCap;
                            link_we    <= 1'b1;
                        end
                    end else begin
                        illegal <= 1'b1;
                    end
                    done  <= 1'b1;
                    state <= FINISH;
                end
                FINISH: begin
                    // pc_out and link_value deliberately hold their last value.
                    pc_load      <= 1'b0;
                    link_we      <= 1'b0;
                    branch_taken <= 1'b0;
                    illegal      <= 1'b0;
                    done         <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - self-checking bench for branch_sequencer

module tb_branch_sequencer;

    localparam logic [4:0] OPC_BR  = 5'b10010;
    localparam logic [4:0] OPC_JR  = 5'b10011;
    localparam logic [4:0] OPC_JAL = 5'b10100;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] ir;
    logic [31:0] pc_in;
    logic [31:0] ra_value;
    logic        con_ff_out;
    logic        con_in;
    logic [31:0] pc_out;
    logic        pc_load;
    logic [31:0] link_value;
    logic        link_we;
    logic        branch_taken;
    logic        illegal;
    logic        busy;
    logic        done;

    branch_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .ir(ir), .pc_in(pc_in),
        .ra_value(ra_value), .con_ff_out(con_ff_out), .con_in(con_in),
        .pc_out(pc_out), .pc_load(pc_load), .link_value(link_value),
        .link_we(link_we), .branch_taken(branch_taken), .illegal(illegal),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        isBr;
        int          latency;
        logic        pcLoad;
        logic [31:0] pcOut;
        logic        linkWe;
        logic [31:0] linkValue;
        logic        taken;
        logic        illegal;
    } exp_t;

    exp_t        sb[$];
    int          nCompared = 0;
    int          nMismatch = 0;
    logic [31:0] lastPc    = 32'h0;
    logic [31:0] lastLink  = 32'h0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatch++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " pc_out"}, pc_out, 32'h0);
        check({tag, " link_value"}, link_value, 32'h0);
        check({tag, " flags"},
              {25'h0, con_in, pc_load, link_we, branch_taken, illegal, busy, done}, 32'h0);
    endtask

    task automatic runOp(input string tag, input logic [4:0] op, input logic [18:0] disp,
                         input logic [31:0] pc, input logic [31:0] ra,
                         input logic con, input logic restart);
        exp_t        e;
        exp_t        got;
        logic [31:0] target;
        logic        seen;
        seen        = 1'b0;
        e.isBr      = (op == OPC_BR);
        e.latency   = e.isBr ? 3 : 2;
        e.linkWe    = (op == OPC_JAL);
        e.illegal   = !(e.isBr || op == OPC_JR || op == OPC_JAL);
        e.pcLoad    = e.isBr ? con : !e.illegal;
        e.taken     = e.pcLoad;
        target      = e.isBr ? pc + {{13{disp[18]}}, disp} : ra;
        e.pcOut     = e.pcLoad ? target : lastPc;
        e.linkValue = e.linkWe ? pc : lastLink;
        lastPc      = e.pcOut;
        lastLink    = e.linkValue;
        sb.push_back(e);

        ir       = {op, 8'h5A, disp};
        pc_in    = pc;
        ra_value = ra;
        start    = 1'b1;
        tick();
        // Operands change (and start may re-pulse) after acceptance.
        start    = restart;
        ir       = $urandom;
        pc_in    = $urandom;
        ra_value = $urandom;
        for (int k = 1; k <= 6; k++) begin
            con_ff_out = (k == 2) ? con : ~con;
            if (k == 2) start = 1'b0;
            check({tag, " con_in"}, {31'h0, con_in}, {31'h0, e.isBr && (k == 1)});
            if (done) begin
                seen = 1'b1;
                got  = sb.pop_front();
                check({tag, " latency"}, k, got.latency);
                check({tag, " pc_load"}, {31'h0, pc_load}, {31'h0, got.pcLoad});
                check({tag, " pc_out"}, pc_out, got.pcOut);
                check({tag, " link_we"}, {31'h0, link_we}, {31'h0, got.linkWe});
                check({tag, " link_value"}, link_value, got.linkValue);
                check({tag, " branch_taken"}, {31'h0, branch_taken}, {31'h0, got.taken});
                check({tag, " illegal"}, {31'h0, illegal}, {31'h0, got.illegal});
                check({tag, " busy"}, {31'h0, busy}, 32'h1);
                break;
            end
            check({tag, " early strobes"}, {30'h0, pc_load, link_we}, 32'h0);
            check({tag, " busy"}, {31'h0, busy}, 32'h1);
            tick();
        end
        check({tag, " done seen"}, {31'h0, seen}, 32'h1);
        con_ff_out = 1'b0;
        start      = 1'b0;
        tick();
        check({tag, " post flags"}, {29'h0, pc_load, busy, done}, 32'h0);
        tick();
        check({tag, " idle busy"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        ir         = 32'h0;
        pc_in      = 32'h0;
        ra_value   = 32'h0;
        con_ff_out = 1'b0;
        tick();
        tick();
        checkAllZero("reset state");
        reset = 1'b0;
        tick();

        runOp("br taken",      OPC_BR, 19'h00010, 32'h00000100, 32'h0, 1'b1, 1'b0);
        check("br taken value", pc_out, 32'h00000110);
        runOp("br not taken",  OPC_BR, 19'h7FFFC, 32'h00000100, 32'h0, 1'b0, 1'b0);
        runOp("br negative",   OPC_BR, 19'h7FFFC, 32'h00000100, 32'h0, 1'b1, 1'b0);
        check("br negative value", pc_out, 32'h000000FC);
        runOp("jal",           OPC_JAL, 19'h00000, 32'h00000024, 32'h00000400, 1'b0, 1'b0);
        runOp("jr",            OPC_JR, 19'h12345, 32'h00000800, 32'h12345678, 1'b1, 1'b0);
        runOp("illegal",       5'b00000, 19'h00010, 32'h00000200, 32'h00000300, 1'b0, 1'b1);

        // Reset asserted while the branch sits in SAMPLE.
        ir       = {OPC_BR, 8'h00, 19'h00010};
        pc_in    = 32'h00000100;
        start    = 1'b1;
        tick();
        start      = 1'b0;
        con_ff_out = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        con_ff_out = 1'b0;
        checkAllZero("reset mid-branch");
        lastPc   = 32'h0;
        lastLink = 32'h0;
        for (int i = 0; i < 3; i++) begin
            check("after abort", {30'h0, pc_load, done}, 32'h0);
            tick();
        end

        // reset and start together: start is dropped.
        reset = 1'b1;
        start = 1'b1;
        ir    = {OPC_JR, 27'h0};
        tick();
        reset = 1'b0;
        start = 1'b0;
        tick();
        check("reset+start busy", {31'h0, busy}, 32'h0);
        tick();
        check("reset+start done", {31'h0, done}, 32'h0);

        runOp("br wrap", OPC_BR, 19'h00008, 32'hFFFFFFFC, 32'h0, 1'b1, 1'b0);
        check("br wrap value", pc_out, 32'h00000004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Drives the conditional-branch flip-flop and consumes its result.
- For each branch/jump instruction handed over by the control unit, it:
  - strobes the condition flop's enable (con_in),
  - samples the registered CON result,
  - computes the branch/jump target and issues a single-cycle PC load. For jal it also issues a link-register write.
- Sits between the control sequencer, the CON flop, and the PC/register-file write ports.

Parameters:
- OPC_BR, 5'b10010, opcode (IR[31:27]) of conditional branch
- OPC_JR, 5'b10011, opcode of jump-register
- OPC_JAL, 5'b10100, opcode of jump-and-link
- C_WIDTH, 19, width of branch displacement field IR[C_WIDTH-1:0]

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; accepted only in IDLE
- ir  in  32  instruction word, sampled with start
- pc_in  in  32  already-incremented PC, sampled with start
- ra_value  in  32  Ra register contents, sampled with start
- con_ff_out  in  1  registered branch condition from CON flop
- con_in  out  1  one-cycle enable to CON flop
- pc_out  out  32  new PC value, valid when pc_load=1
- pc_load  out  1  one-cycle PC write enable
- link_value  out  32  return address for jal
- link_we  out  1  one-cycle link-register write enable
- branch_taken  out  1  asserted with done when PC was loaded
- illegal  out  1  asserted with done for unsupported opcode
- busy  out  1  high from cycle after acceptance through done cycle
- done  out  1  one-cycle completion pulse

Behaviour:
- All outputs are registered. Reset values:
  - all 1-bit outputs = 0
  - pc_out = 0, link_value = 0
  - state = IDLE
- States: IDLE, STROBE, SAMPLE, JUMP, FINISH.
- IDLE:
  - start=1 at edge N: capture ir, pc_in, ra_value into internal registers; set busy.
  - If opcode==OPC_BR: go to STROBE and set con_in<=1.
  - Any other opcode: go to JUMP.
  - start=0: stay in IDLE.
- STROBE (cycle N+1):
  - con_in is high for exactly this cycle; the CON flop captures at edge N+1.
  - Next state is SAMPLE; con_in<=0.
- SAMPLE (cycle N+2):
  - con_ff_out is valid and is sampled at edge N+2.
  - If 1: pc_out<=pc_c + sext(ir_c[C_WIDTH-1:0]), pc_load<=1, branch_taken<=1.
  - If 0: no load.
  - In both cases done<=1; go to FINISH.
- JUMP (cycle N+1):
  - OPC_JR: pc_out<=ra_c, pc_load<=1, branch_taken<=1.
  - OPC_JAL: as OPC_JR, plus link_value<=pc_c and link_we<=1.
  - Other opcode: illegal<=1, with no pc_load and no link_we.
  - done<=1; go to FINISH.
- FINISH:
  - done and its qualifiers are visible for this single cycle.
  - At the next edge, clear pc_load, link_we, branch_taken, illegal, done and busy; return to IDLE.
  - pc_out and link_value hold their last value.
- Latency from start edge to done-high cycle:
  - br: done high in cycle N+3.
  - jr / jal / illegal: done high in cycle N+2.
  - No back-to-back acceptance: the next start is accepted at the earliest on the FINISH→IDLE edge + 1.
- Arithmetic:
  - Sign-extend from bit C_WIDTH-1 to 32 bits.
  - Addition is modulo 2^32; wrap-around is silently discarded.
- start while busy (not IDLE): ignored, no effect on captured operands.
- Inputs ir, pc_in and ra_value may change after acceptance without affecting the result.
- con_ff_out is ignored in every state except SAMPLE.
- reset=1 in any state, including mid-operation:
  - At that edge, return to IDLE with all outputs at reset values.
  - No pc_load, link_we or done may be produced for the aborted instruction.
- reset and start in the same cycle: reset wins and start is dropped.

Test Plan:
- Taken branch:
  - Stimulus: start with ir opcode OPC_BR, C=19'h00010, pc_in=32'h00000100, con_ff_out=1 in cycle N+2.
  - Required: con_in high only in N+1; in N+3 pc_load=1, pc_out=32'h00000110, branch_taken=1, done=1.
- Not-taken branch with negative displacement:
  - Stimulus: C=19'h7FFFC, pc_in=32'h00000100, con_ff_out=0.
  - Required: done=1 in N+3; pc_load=0, branch_taken=0; pc_out unchanged.
  - Repeat with con_ff_out=1: required pc_out=32'h000000FC.
- jal:
  - Stimulus: ra_value=32'h00000400, pc_in=32'h00000024.
  - Required: in N+2 pc_load=1, pc_out=32'h00000400, link_we=1, link_value=32'h00000024, done=1, con_in never asserted.
- Illegal opcode and start-while-busy:
  - Stimulus: opcode 5'b00000; start re-pulsed in N+1.
  - Required: done=1 and illegal=1 in N+2, pc_load=0, link_we=0; the second start is ignored.
- Reset mid-branch and wrap-around:
  - Stimulus: reset asserted in SAMPLE.
  - Required: no done or pc_load follows; all outputs 0 next cycle.
  - Then a taken branch with pc_in=32'hFFFFFFFC, C=19'h00008: required pc_out=32'h00000004.
